// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV32I pipeline.
// Holds the byte-addressable data memory (synchronous read, byte-enabled
// write), steers store data onto byte lanes, extracts and extends load data,
// and registers all writeback-bound signals into the MEM/WB boundary.
// Optional build macro: MEM_MISALIGN_TRAP_EN adds misaligned_MEMWB and
// suppresses misaligned stores / load writebacks. Without it, misaligned
// half/word accesses are forced onto aligned lanes.
module memory_stage #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_out_EXMEM,
  input  logic [2:0]  funct3_EXMEM,
  input  logic        mem_wr_en_EXMEM,
  input  logic [31:0] rs2_data_EXMEM,
  input  logic        reg_wr_en_EXMEM,
  input  logic [1:0]  reg_wr_ctrl_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic [31:0] pc_4_EXMEM,
  output logic [31:0] ALU_out_MEMWB,
  output logic [31:0] mem_rd_data_MEMWB,
  output logic        reg_wr_en_MEMWB,
  output logic [1:0]  reg_wr_ctrl_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic [31:0] pc_4_MEMWB
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_MEMWB
`endif
);

  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] dmem [DMEM_WORDS];

  logic [DMEM_AW-1:0] word_idx;
  logic [1:0]         byte_off;
  logic [3:0]         byte_en;
  logic [31:0]        wr_data;
  logic               wr_fire;
  logic               mis_load;

  logic [31:0] rd_word_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Upper address bits are dropped, so the memory aliases every 4*DMEM_WORDS bytes.
  assign word_idx = ALU_out_EXMEM[DMEM_AW+1:2];
  assign byte_off = ALU_out_EXMEM[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_access;
  logic mis_flag;
  // Without a dedicated load strobe, a load is a register-writing access that is not a store.
  assign mis_access = ((funct3_EXMEM[1:0] == 2'b01) && byte_off[0]) ||
                      ((funct3_EXMEM == 3'b010) && (byte_off != 2'b00));
  assign mis_flag   = mis_access && (mem_wr_en_EXMEM || reg_wr_en_EXMEM);
  assign mis_load   = mis_access && reg_wr_en_EXMEM && !mem_wr_en_EXMEM;
  assign wr_fire    = mem_wr_en_EXMEM && !reset && (byte_en != 4'b0000) && !mis_access;
`else
  assign mis_load   = 1'b0;
  assign wr_fire    = mem_wr_en_EXMEM && !reset && (byte_en != 4'b0000);
`endif

  // Store lane steering: replicate narrow data across lanes and pick byte enables.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = rs2_data_EXMEM;
    case (funct3_EXMEM)
      3'b000: begin
        byte_en = 4'b0001 << byte_off;
        wr_data = {4{rs2_data_EXMEM[7:0]}};
      end
      3'b001: begin
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{rs2_data_EXMEM[15:0]}};
      end
      3'b010: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Synchronous read plus MEM/WB pipeline registers; read word holds during stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_q         <= '0;
      funct3_q          <= '0;
      off_q             <= '0;
      ALU_out_MEMWB     <= '0;
      reg_wr_en_MEMWB   <= 1'b0;
      reg_wr_ctrl_MEMWB <= '0;
      rd_MEMWB          <= '0;
      pc_4_MEMWB        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_MEMWB  <= 1'b0;
`endif
    end else begin
      if (!mem_wr_en_EXMEM) rd_word_q <= dmem[word_idx];
      funct3_q          <= funct3_EXMEM;
      off_q             <= byte_off;
      ALU_out_MEMWB     <= ALU_out_EXMEM;
      reg_wr_en_MEMWB   <= reg_wr_en_EXMEM && !mis_load;
      reg_wr_ctrl_MEMWB <= reg_wr_ctrl_EXMEM;
      rd_MEMWB          <= rd_EXMEM;
      pc_4_MEMWB        <= pc_4_EXMEM;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_MEMWB  <= mis_flag;
`endif
    end
  end

  assign ld_byte = rd_word_q[8*off_q +: 8];
  assign ld_half = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

  // Load extraction with sign/zero extension from the registered word.
  always_comb begin
    mem_rd_data_MEMWB = '0;
    case (funct3_q)
      3'b000:  mem_rd_data_MEMWB = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  mem_rd_data_MEMWB = {24'h0, ld_byte};
      3'b001:  mem_rd_data_MEMWB = {{16{ld_half[15]}}, ld_half};
      3'b101:  mem_rd_data_MEMWB = {16'h0, ld_half};
      3'b010:  mem_rd_data_MEMWB = rd_word_q;
      default: mem_rd_data_MEMWB = '0;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (misaligned_MEMWB) mem_rd_data_MEMWB = '0;
`endif
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage (default build).
// A byte-array reference model predicts each cycle's MEM/WB outputs; the
// driver queues predictions and a separate monitor compares them.
module tb_memory_stage;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_out_EXMEM;
  logic [2:0]  funct3_EXMEM;
  logic        mem_wr_en_EXMEM;
  logic [31:0] rs2_data_EXMEM;
  logic        reg_wr_en_EXMEM;
  logic [1:0]  reg_wr_ctrl_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic [31:0] pc_4_EXMEM;
  logic [31:0] ALU_out_MEMWB;
  logic [31:0] mem_rd_data_MEMWB;
  logic        reg_wr_en_MEMWB;
  logic [1:0]  reg_wr_ctrl_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic [31:0] pc_4_MEMWB;

  memory_stage #(.DMEM_WORDS(WORDS)) dut (
    .clk               (clk),
    .reset             (reset),
    .ALU_out_EXMEM     (ALU_out_EXMEM),
    .funct3_EXMEM      (funct3_EXMEM),
    .mem_wr_en_EXMEM   (mem_wr_en_EXMEM),
    .rs2_data_EXMEM    (rs2_data_EXMEM),
    .reg_wr_en_EXMEM   (reg_wr_en_EXMEM),
    .reg_wr_ctrl_EXMEM (reg_wr_ctrl_EXMEM),
    .rd_EXMEM          (rd_EXMEM),
    .pc_4_EXMEM        (pc_4_EXMEM),
    .ALU_out_MEMWB     (ALU_out_MEMWB),
    .mem_rd_data_MEMWB (mem_rd_data_MEMWB),
    .reg_wr_en_MEMWB   (reg_wr_en_MEMWB),
    .reg_wr_ctrl_MEMWB (reg_wr_ctrl_MEMWB),
    .rd_MEMWB          (rd_MEMWB),
    .pc_4_MEMWB        (pc_4_MEMWB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdd;
    logic        rwe;
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  bm [4*WORDS];
  logic [31:0] held = 32'h0;

  function automatic logic [31:0] model_word(input int unsigned widx);
    return {bm[4*widx+3], bm[4*widx+2], bm[4*widx+1], bm[4*widx]};
  endfunction

  // Load formatting from plain arithmetic on the whole word.
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  // One EX/MEM transaction: drive, predict, queue.
  task automatic issue(input logic rst, input logic [31:0] addr, input logic [2:0] f3,
                       input logic we, input logic [31:0] data, input logic rwe);
    exp_t        e;
    int unsigned widx;
    int unsigned base;
    logic [1:0]  off;
    @(negedge clk);
    reset             = rst;
    ALU_out_EXMEM     = addr;
    funct3_EXMEM      = f3;
    mem_wr_en_EXMEM   = we;
    rs2_data_EXMEM    = data;
    reg_wr_en_EXMEM   = rwe;
    reg_wr_ctrl_EXMEM = 2'($urandom_range(0, 3));
    rd_EXMEM          = 5'($urandom_range(0, 31));
    pc_4_EXMEM        = $urandom;
    off  = addr[1:0];
    widx = (addr / 4) % WORDS;
    base = 4 * widx;
    if (rst) begin
      e    = '0;
      held = 32'h0;
    end else begin
      if (!we) held = model_word(widx);
      e.alu  = addr;
      e.rdd  = fmt(held, f3, off);
      e.rwe  = rwe;
      e.ctrl = reg_wr_ctrl_EXMEM;
      e.rd   = rd_EXMEM;
      e.pc4  = pc_4_EXMEM;
      if (we) begin
        case (f3)
          3'd0: bm[base + off] = data[7:0];
          3'd1: begin
            bm[base + (off & 2)]     = data[7:0];
            bm[base + (off & 2) + 1] = data[15:8];
          end
          3'd2: for (int k = 0; k < 4; k++) bm[base + k] = data[8*k +: 8];
          default: ;
        endcase
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid one cycle after issue; sample just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alu_out",     ALU_out_MEMWB,            e.alu);
        chk("mem_rd_data", mem_rd_data_MEMWB,        e.rdd);
        chk("reg_wr_en",   32'(reg_wr_en_MEMWB),     32'(e.rwe));
        chk("reg_wr_ctrl", 32'(reg_wr_ctrl_MEMWB),   32'(e.ctrl));
        chk("rd",          32'(rd_MEMWB),            32'(e.rd));
        chk("pc_4",        pc_4_MEMWB,               e.pc4);
      end
    end
  end

  initial begin
    logic [31:0] a;
    reset = 1'b1; ALU_out_EXMEM = '0; funct3_EXMEM = '0; mem_wr_en_EXMEM = 1'b0;
    rs2_data_EXMEM = '0; reg_wr_en_EXMEM = 1'b0; reg_wr_ctrl_EXMEM = '0;
    rd_EXMEM = '0; pc_4_EXMEM = '0;
    for (int i = 0; i < 4*WORDS; i++) bm[i] = 8'h0;

    issue(1'b1, 32'h0, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h0, 3'd2, 1'b0, 32'h0, 1'b1);

    // Fill words 0..63 so every later read hits known data.
    for (int w = 0; w < 64; w++) issue(1'b0, 32'(4*w), 3'd2, 1'b1, $urandom, 1'b0);

    // Directed cases.
    issue(1'b0, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 3'd2, 1'b1, 32'h11223344, 1'b0);
    issue(1'b0, 32'h21, 3'd0, 1'b1, 32'h000000AB, 1'b0);
    issue(1'b0, 32'h21, 3'd4, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h21, 3'd0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h30, 3'd2, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h32, 3'd1, 1'b1, 32'h00008001, 1'b0);
    issue(1'b0, 32'h32, 3'd1, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h32, 3'd5, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h30, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h1004, 3'd2, 1'b1, 32'h5, 1'b0);
    issue(1'b0, 32'h0004, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h40, 3'd2, 1'b1, 32'hCAFE0040, 1'b0);
    issue(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h40, 3'd2, 1'b1, 32'h7, 1'b1);
    issue(1'b0, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h46, 3'd7, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h44, 3'd4, 1'b1, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 32'h44, 3'd2, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with aliased upper address bits and occasional resets.
    for (int n = 0; n < 500; n++) begin
      logic we;
      a  = $urandom & 32'hFFFF_F0FF;
      we = ($urandom_range(0, 2) == 0);
      issue(($urandom_range(0, 39) == 0), a, 3'($urandom_range(0, 7)), we, $urandom, !we);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
